// File: rtl/spi_status_if.sv
// spi_status_if: FIFO flags, host strobes and status outputs of spi_status_reg.
interface spi_status_if #(parameter int ERR_CNT_W = 8);
  logic                 SENDER_EMPTY_STATE;
  logic                 SENDER_FULL_STATE;
  logic                 RECEIVER_EMPTY_STATE;
  logic                 RECEIVER_FULL_STATE;
  logic                 SENDER_WRITE;
  logic                 RECEIVER_READ;
  logic                 CONNECTION_FAILED_STATE;
  logic                 CLEAR_WR;
  logic [7:0]           CLEAR_MASK;
  logic [7:0]           IRQ_MASK;
  logic                 ERR_CNT_CLR;
  logic [7:0]           STATUS;
  logic                 IRQ;
  logic [ERR_CNT_W-1:0] ERR_COUNT;
  modport master (
    output SENDER_EMPTY_STATE, SENDER_FULL_STATE, RECEIVER_EMPTY_STATE, RECEIVER_FULL_STATE,
           SENDER_WRITE, RECEIVER_READ, CONNECTION_FAILED_STATE, CLEAR_WR, CLEAR_MASK,
           IRQ_MASK, ERR_CNT_CLR,
    input  STATUS, IRQ, ERR_COUNT
  );
  modport slave (
    input  SENDER_EMPTY_STATE, SENDER_FULL_STATE, RECEIVER_EMPTY_STATE, RECEIVER_FULL_STATE,
           SENDER_WRITE, RECEIVER_READ, CONNECTION_FAILED_STATE, CLEAR_WR, CLEAR_MASK,
           IRQ_MASK, ERR_CNT_CLR,
    output STATUS, IRQ, ERR_COUNT
  );
endinterface

// File: rtl/spi_status_reg.sv
// spi_status_reg: SPI status byte with sticky W1C bits, masked IRQ and optional error counter.
// Define SPI_STATUS_ERR_CNT_EN to build the saturating ERR_COUNT; otherwise it reads 0.
module spi_status_reg #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input logic         S_CLK,
  input logic         CLR,
  spi_status_if.slave bus
);
  localparam logic [7:0] STICKY = 8'hAB;
  logic       fail_s, prev_empty, irq_q;
  logic       se, re;
  logic [7:0] status_q, status_nx, set, clr_m;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign fail_s = bus.CONNECTION_FAILED_STATE;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge S_CLK or posedge CLR)
        if (CLR) sync <= '0;
        else begin
          sync[0] <= bus.CONNECTION_FAILED_STATE;
          for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
      assign fail_s = sync[SYNC_STAGES-1];
    end
  endgenerate
  assign se = bus.SENDER_EMPTY_STATE;
  assign re = bus.RECEIVER_EMPTY_STATE;
  // Set terms sit at their STATUS bit positions so set-wins-over-clear is a plain OR.
  assign set = {fail_s, 1'b0, se & ~prev_empty, 1'b0,
                bus.SENDER_WRITE & ~se, 1'b0,
                bus.RECEIVER_READ & re, bus.SENDER_WRITE & bus.SENDER_FULL_STATE};
  assign clr_m = bus.CLEAR_WR ? bus.CLEAR_MASK : 8'h00;
  always_comb
    status_nx = ((set | (status_q & ~clr_m)) & STICKY)
              | {1'b0, ~re, 1'b0, se, 1'b0, bus.RECEIVER_FULL_STATE, 2'b00};
  always_ff @(posedge S_CLK or posedge CLR)
    if (CLR) begin
      status_q   <= 8'h30;
      irq_q      <= 1'b0;
      prev_empty <= 1'b1;
    end else begin
      status_q   <= status_nx;
      irq_q      <= |(status_nx & bus.IRQ_MASK);
      prev_empty <= se;
    end
  assign bus.STATUS = status_q;
  assign bus.IRQ    = irq_q;
`ifdef SPI_STATUS_ERR_CNT_EN
  logic                 fail_d, err_ev;
  logic [ERR_CNT_W-1:0] cnt;
  assign err_ev = set[0] | set[1] | set[3] | (fail_s & ~fail_d);
  always_ff @(posedge S_CLK or posedge CLR)
    if (CLR) begin
      cnt    <= '0;
      fail_d <= 1'b0;
    end else begin
      fail_d <= fail_s;
      cnt    <= bus.ERR_CNT_CLR ? ERR_CNT_W'(err_ev) : (err_ev && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  assign bus.ERR_COUNT = cnt;
`else
  assign bus.ERR_COUNT = {ERR_CNT_W{bus.ERR_CNT_CLR & 1'b0}};
`endif
endmodule

// File: tb/tb_spi_status_reg.sv
// tb_spi_status_reg: directed and random stimulus against a bit-map reference model.
module tb_spi_status_reg;
  localparam int SS = 2;
  localparam int W  = 2;
  logic S_CLK = 1'b0;
  logic CLR   = 1'b0;
  spi_status_if #(.ERR_CNT_W(W)) bus();
  spi_status_reg #(.SYNC_STAGES(SS), .ERR_CNT_W(W)) dut (.S_CLK(S_CLK), .CLR(CLR), .bus(bus));
  always #5 S_CLK = ~S_CLK;
  int checks = 0, failures = 0;
  logic [7:0] m_st;
  logic       m_irq, m_prev, m_lvl_prev;
  int         m_cnt;
  logic       hist[$];
  int         sat_exp[5] = '{1, 2, 3, 3, 3};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_st = 8'h30; m_irq = 1'b0; m_cnt = 0; m_prev = 1'b1; m_lvl_prev = 1'b0;
    hist.delete();
    repeat (SS) hist.push_back(1'b0);
  endfunction
  // Apply the bit-map rules to the inputs present before the coming edge.
  function automatic void model_edge();
    logic lvl, ovf, unf, wcol, done, ev;
    logic [7:0] set, clr;
    hist.push_back(bus.CONNECTION_FAILED_STATE);
    lvl  = hist.pop_front();
    ovf  = bus.SENDER_WRITE & bus.SENDER_FULL_STATE;
    unf  = bus.RECEIVER_READ & bus.RECEIVER_EMPTY_STATE;
    wcol = bus.SENDER_WRITE & ~bus.SENDER_EMPTY_STATE;
    done = bus.SENDER_EMPTY_STATE & ~m_prev;
    set  = 8'h00;
    set[0] = ovf; set[1] = unf; set[3] = wcol; set[5] = done; set[7] = lvl;
    clr  = bus.CLEAR_WR ? bus.CLEAR_MASK : 8'h00;
    for (int i = 0; i < 8; i++)
      if (i inside {0, 1, 3, 5, 7}) m_st[i] = set[i] ? 1'b1 : (clr[i] ? 1'b0 : m_st[i]);
    m_st[2] = bus.RECEIVER_FULL_STATE;
    m_st[4] = bus.SENDER_EMPTY_STATE;
    m_st[6] = ~bus.RECEIVER_EMPTY_STATE;
    m_irq = (m_st & bus.IRQ_MASK) != 0;
`ifdef SPI_STATUS_ERR_CNT_EN
    ev = ovf | unf | wcol | (lvl & ~m_lvl_prev);
    if (bus.ERR_CNT_CLR) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < (1 << W) - 1) m_cnt = m_cnt + 1;
`else
    ev = 1'b0;
`endif
    m_prev = bus.SENDER_EMPTY_STATE;
    m_lvl_prev = lvl;
  endfunction
  task automatic step(string tag);
    model_edge();
    @(posedge S_CLK);
    #1;
    check({tag, ".status"}, 32'(bus.STATUS), 32'(m_st));
    check({tag, ".irq"}, 32'(bus.IRQ), 32'(m_irq));
    check({tag, ".cnt"}, 32'(bus.ERR_COUNT), 32'(m_cnt));
  endtask
  task automatic async_reset(string tag);
    #2 CLR = 1'b1;
    #1;
    check({tag, ".rst_status"}, 32'(bus.STATUS), 32'h30);
    check({tag, ".rst_irq"}, 32'(bus.IRQ), 32'h0);
    check({tag, ".rst_cnt"}, 32'(bus.ERR_COUNT), 32'h0);
    model_reset();
    #1 CLR = 1'b0;
  endtask
  initial begin
    {bus.SENDER_EMPTY_STATE, bus.SENDER_FULL_STATE, bus.RECEIVER_EMPTY_STATE,
     bus.RECEIVER_FULL_STATE, bus.SENDER_WRITE, bus.RECEIVER_READ,
     bus.CONNECTION_FAILED_STATE, bus.CLEAR_WR, bus.ERR_CNT_CLR} = '0;
    bus.CLEAR_MASK = 8'h00;
    bus.IRQ_MASK   = 8'h00;
    #1;
    async_reset("reset");
    bus.RECEIVER_EMPTY_STATE = 1'b1;
    bus.SENDER_FULL_STATE = 1'b1;
    bus.CLEAR_WR = 1'b1; bus.CLEAR_MASK = 8'hFF;
    step("prep");
    check("prep.byte", 32'(bus.STATUS), 32'h00);
    bus.CLEAR_WR = 1'b0; bus.SENDER_WRITE = 1'b1; bus.IRQ_MASK = 8'h01;
    step("ovf");
    check("ovf.byte", 32'(bus.STATUS), 32'h09);
    check("ovf.irq_const", 32'(bus.IRQ), 32'h1);
`ifdef SPI_STATUS_ERR_CNT_EN
    check("ovf.cnt_const", 32'(bus.ERR_COUNT), 32'h1);
`endif
    bus.SENDER_WRITE = 1'b0; bus.RECEIVER_READ = 1'b1;
    bus.CLEAR_WR = 1'b1; bus.CLEAR_MASK = 8'hFF;
    step("setwin");
    check("setwin.byte", 32'(bus.STATUS), 32'h02);
    bus.RECEIVER_READ = 1'b0; bus.CLEAR_WR = 1'b0;
    bus.SENDER_FULL_STATE = 1'b0; bus.SENDER_EMPTY_STATE = 1'b1;
    step("done");
    check("done.byte", 32'(bus.STATUS), 32'h32);
    repeat (4) step("done_hold");
    check("done_hold.byte", 32'(bus.STATUS), 32'h32);
    bus.CLEAR_WR = 1'b1; bus.CLEAR_MASK = 8'h20;
    step("done_clr");
    bus.CLEAR_WR = 1'b0;
    repeat (3) step("done_after");
    check("done_after.byte", 32'(bus.STATUS), 32'h12);
    bus.CONNECTION_FAILED_STATE = 1'b1;
    step("fail1");
    step("fail2");
    check("fail2.bit7", 32'(bus.STATUS[7]), 32'h0);
    step("fail3");
    check("fail3.bit7", 32'(bus.STATUS[7]), 32'h1);
    for (int i = 0; i < 7; i++) begin
      bus.CLEAR_WR = (i == 2); bus.CLEAR_MASK = 8'h80;
      step("fail_hi");
      check("fail_hi.bit7", 32'(bus.STATUS[7]), 32'h1);
    end
    bus.CLEAR_WR = 1'b0; bus.CONNECTION_FAILED_STATE = 1'b0;
    repeat (2) step("fail_fall");
    bus.CLEAR_WR = 1'b1;
    step("fail_clr");
    check("fail_clr.bit7", 32'(bus.STATUS[7]), 32'h0);
    bus.CLEAR_WR = 1'b0; bus.ERR_CNT_CLR = 1'b1;
    step("sat_clr0");
    bus.ERR_CNT_CLR = 1'b0;
    bus.SENDER_EMPTY_STATE = 1'b0; bus.SENDER_FULL_STATE = 1'b1; bus.SENDER_WRITE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("sat");
`ifdef SPI_STATUS_ERR_CNT_EN
      check("sat.cnt_const", 32'(bus.ERR_COUNT), 32'(sat_exp[i]));
`endif
    end
    bus.SENDER_WRITE = 1'b0; bus.ERR_CNT_CLR = 1'b1;
    step("sat_clr");
    check("sat_clr.cnt_const", 32'(bus.ERR_COUNT), 32'h0);
    bus.ERR_CNT_CLR = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bus.SENDER_EMPTY_STATE   = 1'($urandom_range(0, 1));
      bus.SENDER_FULL_STATE    = 1'($urandom_range(0, 1));
      bus.RECEIVER_EMPTY_STATE = 1'($urandom_range(0, 1));
      bus.RECEIVER_FULL_STATE  = 1'($urandom_range(0, 1));
      bus.SENDER_WRITE         = 1'($urandom_range(0, 1));
      bus.RECEIVER_READ        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.CONNECTION_FAILED_STATE = ~bus.CONNECTION_FAILED_STATE;
      bus.CLEAR_WR    = ($urandom_range(0, 3) == 0);
      bus.CLEAR_MASK  = 8'($urandom);
      bus.IRQ_MASK    = 8'($urandom);
      bus.ERR_CNT_CLR = ($urandom_range(0, 9) == 0);
      if (n % 60 == 59) async_reset("rnd");
      step("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
